// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Requester ids double as round-robin pointer values.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick. req[0] is fetch, req[1] is data;
// on a tie the port that did not win last time is chosen.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_IF;
    case (req)
      2'b01:   grant_id = REQ_IF;
      2'b10:   grant_id = REQ_D;
      2'b11:   grant_id = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
      default: grant_id = REQ_IF;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and load/store requesters.
// Each access runs ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP; ties go round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_rd_wr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  req_id_t          last_grant_reg;
  req_id_t          cur_id_reg;
  logic             cur_rd_reg;

  logic    grant_valid;
  req_id_t grant_id;

  rr_arbiter2 u_rr (
    .req         ({d_req, if_req}),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= REQ_IF;
      cur_id_reg     <= REQ_IF;
      cur_rd_reg     <= MEM_RD;
      if_gnt         <= 1'b0;
      if_rvalid      <= 1'b0;
      if_rdata       <= '0;
      d_gnt          <= 1'b0;
      d_rvalid       <= 1'b0;
      d_rdata        <= '0;
      mem_en         <= 1'b0;
      mem_addr       <= '0;
      mem_rd_wr      <= MEM_RD;
      mem_wdata      <= '0;
    end else begin
      // Pulses default low; mem_addr/mem_wdata keep the captured access.
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_rd_wr <= MEM_RD;

      case (state_reg)
        IDLE, RESP: begin
          if (grant_valid) begin
            state_reg      <= ISSUE;
            last_grant_reg <= grant_id;
            cur_id_reg     <= grant_id;
            mem_en         <= 1'b1;
            if (grant_id == REQ_D) begin
              mem_addr   <= d_addr;
              mem_rd_wr  <= d_rd_wr;
              mem_wdata  <= d_wdata;
              cur_rd_reg <= d_rd_wr;
              d_gnt      <= 1'b1;
            end else begin
              mem_addr   <= if_addr;
              mem_rd_wr  <= MEM_RD;
              cur_rd_reg <= MEM_RD;
              if_gnt     <= 1'b1;
            end
          end else begin
            state_reg <= IDLE;
          end
        end

        ISSUE: begin
          cnt_reg   <= CNT_W'(MEM_LATENCY);
          state_reg <= WAIT;
        end

        WAIT: begin
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= RESP;
            if (cur_id_reg == REQ_D) begin
              d_rvalid <= 1'b1;
              if (cur_rd_reg == MEM_RD) d_rdata <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
          cnt_reg <= cnt_reg - CNT_W'(1);
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a latency-2 instance (fetch, write, contention, late arrival,
// async reset) and a latency-1 instance (single read and back-to-back fetches).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: MEM_LATENCY = 2
  logic        a_if_req = 1'b0, a_d_req = 1'b0, a_d_rd_wr = 1'b1;
  logic [31:0] a_if_addr = '0, a_d_addr = '0, a_d_wdata = '0;
  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_rd_wr, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  // Instance B: MEM_LATENCY = 1
  logic        b_if_req = 1'b0, b_d_req = 1'b0, b_d_rd_wr = 1'b1;
  logic [31:0] b_if_addr = '0, b_d_addr = '0, b_d_wdata = '0;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_rd_wr, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_addr(a_d_addr), .d_rd_wr(a_d_rd_wr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_rd_wr(a_mem_rd_wr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_addr(b_d_addr), .d_rd_wr(b_d_rd_wr), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rd_wr(b_mem_rd_wr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory contents: one fixed instruction word, everything else addr ^ pattern.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h8002_0000) return 32'h2402_0005;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Memory models: read data is valid only in the single cycle that is
  // LATENCY cycles after the mem_en sampling edge; otherwise garbage.
  logic [31:0] a_pend_addr = '0, b_pend_addr = '0;
  int          a_pend_cnt = 0, b_pend_cnt = 0;
  logic        a_pend_act = 1'b0, b_pend_act = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) a_pend_act <= 1'b0;
    else if (a_mem_en && a_mem_rd_wr) begin
      a_pend_addr <= a_mem_addr; a_pend_cnt <= 1; a_pend_act <= 1'b1;
    end else if (a_pend_act) begin
      if (a_pend_cnt == 0) a_pend_act <= 1'b0;
      else a_pend_cnt <= a_pend_cnt - 1;
    end
  end
  assign a_mem_rdata = (a_pend_act && a_pend_cnt == 0) ? mem_f(a_pend_addr) : 32'hBAD0_BAD0;

  always @(posedge clk or posedge reset) begin
    if (reset) b_pend_act <= 1'b0;
    else if (b_mem_en && b_mem_rd_wr) begin
      b_pend_addr <= b_mem_addr; b_pend_cnt <= 0; b_pend_act <= 1'b1;
    end else if (b_pend_act) begin
      if (b_pend_cnt == 0) b_pend_act <= 1'b0;
      else b_pend_cnt <= b_pend_cnt - 1;
    end
  end
  assign b_mem_rdata = (b_pend_act && b_pend_cnt == 0) ? mem_f(b_pend_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_mem_rd_wr", 32'(a_mem_rd_wr), 32'd1);
    chk("rst_a_mem_en", 32'(a_mem_en), 32'd0);
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_mem_addr", a_mem_addr, 32'd0);
    chk("rst_a_gnts", {30'd0, a_if_gnt, a_d_gnt}, 32'd0);
    chk("rst_a_rvalids", {30'd0, a_if_rvalid, a_d_rvalid}, 32'd0);
    chk("rst_b_mem_rd_wr", 32'(b_mem_rd_wr), 32'd1);
    reset = 1'b0;

    // ---------------- fetch read ----------------
    a_if_req = 1'b1; a_if_addr = 32'h8002_0000;
    step();  // cycle 1
    chk("f_if_gnt_c1", 32'(a_if_gnt), 32'd1);
    chk("f_mem_en_c1", 32'(a_mem_en), 32'd1);
    chk("f_mem_addr_c1", a_mem_addr, 32'h8002_0000);
    chk("f_mem_rd_wr_c1", 32'(a_mem_rd_wr), 32'd1);
    chk("f_d_gnt_c1", 32'(a_d_gnt), 32'd0);
    chk("f_busy_c1", 32'(a_busy), 32'd1);
    a_if_req = 1'b0;
    step();  // cycle 2
    chk("f_if_gnt_c2", 32'(a_if_gnt), 32'd0);
    chk("f_mem_en_c2", 32'(a_mem_en), 32'd0);
    chk("f_mem_addr_hold_c2", a_mem_addr, 32'h8002_0000);
    step();  // cycle 3
    chk("f_if_rvalid_c3", 32'(a_if_rvalid), 32'd0);
    step();  // cycle 4
    chk("f_if_rvalid_c4", 32'(a_if_rvalid), 32'd1);
    chk("f_if_rdata_c4", a_if_rdata, 32'h2402_0005);
    chk("f_d_rvalid_c4", 32'(a_d_rvalid), 32'd0);
    step();  // cycle 5
    chk("f_if_rvalid_c5", 32'(a_if_rvalid), 32'd0);
    chk("f_busy_c5", 32'(a_busy), 32'd0);

    // ---------------- data write ----------------
    a_d_req = 1'b1; a_d_rd_wr = 1'b0; a_d_addr = 32'h8011_FFFC; a_d_wdata = 32'hDEAD_BEEF;
    step();  // cycle 1
    chk("w_d_gnt_c1", 32'(a_d_gnt), 32'd1);
    chk("w_mem_en_c1", 32'(a_mem_en), 32'd1);
    chk("w_mem_rd_wr_c1", 32'(a_mem_rd_wr), 32'd0);
    chk("w_mem_addr_c1", a_mem_addr, 32'h8011_FFFC);
    chk("w_mem_wdata_c1", a_mem_wdata, 32'hDEAD_BEEF);
    a_d_req = 1'b0;
    step();  // cycle 2
    chk("w_mem_en_c2", 32'(a_mem_en), 32'd0);
    chk("w_mem_rd_wr_c2", 32'(a_mem_rd_wr), 32'd1);
    chk("w_mem_wdata_hold_c2", a_mem_wdata, 32'hDEAD_BEEF);
    step();  // cycle 3
    chk("w_d_rvalid_c3", 32'(a_d_rvalid), 32'd0);
    step();  // cycle 4
    chk("w_d_rvalid_c4", 32'(a_d_rvalid), 32'd1);
    chk("w_d_rdata_c4", a_d_rdata, 32'd0);
    chk("w_if_rdata_c4", a_if_rdata, 32'h2402_0005);
    chk("w_if_rvalid_c4", 32'(a_if_rvalid), 32'd0);
    step();  // cycle 5
    chk("w_busy_c5", 32'(a_busy), 32'd0);

    // ---------------- contention from reset ----------------
    reset = 1'b1;
    a_if_req = 1'b1; a_if_addr = 32'h8000_0100;
    a_d_req = 1'b1; a_d_rd_wr = 1'b1; a_d_addr = 32'h9000_0200;
    step();
    reset = 1'b0;  // cycle 0
    for (int c = 1; c <= 17; c++) begin
      step();
      chk($sformatf("c_d_gnt_c%0d", c), 32'(a_d_gnt), 32'(c == 1 || c == 9));
      chk($sformatf("c_if_gnt_c%0d", c), 32'(a_if_gnt), 32'(c == 5 || c == 13));
      chk($sformatf("c_d_rvalid_c%0d", c), 32'(a_d_rvalid), 32'(c == 4 || c == 12));
      chk($sformatf("c_if_rvalid_c%0d", c), 32'(a_if_rvalid), 32'(c == 8 || c == 16));
      if (c == 1 || c == 9) chk($sformatf("c_mem_addr_c%0d", c), a_mem_addr, 32'h9000_0200);
      if (c == 5 || c == 13) chk($sformatf("c_mem_addr_c%0d", c), a_mem_addr, 32'h8000_0100);
      if (c == 4 || c == 12) chk($sformatf("c_d_rdata_c%0d", c), a_d_rdata, 32'h35A5_585A);
      if (c == 8 || c == 16) chk($sformatf("c_if_rdata_c%0d", c), a_if_rdata, 32'h25A5_5B5A);
      if (c == 13) begin a_if_req = 1'b0; a_d_req = 1'b0; end
    end
    chk("c_busy_c17", 32'(a_busy), 32'd0);

    // ---------------- late arrival ----------------
    a_if_req = 1'b1; a_if_addr = 32'h8002_0000;
    step();  // cycle 1
    chk("l_if_gnt_c1", 32'(a_if_gnt), 32'd1);
    a_if_req = 1'b0;
    step();  // cycle 2 (WAIT)
    a_d_req = 1'b1; a_d_rd_wr = 1'b1; a_d_addr = 32'h9000_0300;
    step();  // cycle 3
    chk("l_d_gnt_c3", 32'(a_d_gnt), 32'd0);
    step();  // cycle 4 (RESP)
    chk("l_if_rvalid_c4", 32'(a_if_rvalid), 32'd1);
    chk("l_if_rdata_c4", a_if_rdata, 32'h2402_0005);
    chk("l_d_gnt_c4", 32'(a_d_gnt), 32'd0);
    step();  // cycle 5
    chk("l_d_gnt_c5", 32'(a_d_gnt), 32'd1);
    chk("l_mem_addr_c5", a_mem_addr, 32'h9000_0300);
    a_d_req = 1'b0;
    step(); step(); step();  // cycle 8
    chk("l_d_rvalid_c8", 32'(a_d_rvalid), 32'd1);
    chk("l_d_rdata_c8", a_d_rdata, 32'h35A5_595A);
    chk("l_if_rdata_c8", a_if_rdata, 32'h2402_0005);
    chk("l_if_rvalid_c8", 32'(a_if_rvalid), 32'd0);
    step();  // cycle 9
    chk("l_busy_c9", 32'(a_busy), 32'd0);

    // ---------------- async reset mid-WAIT ----------------
    a_d_req = 1'b1; a_d_rd_wr = 1'b1; a_d_addr = 32'h9000_0400;
    step();  // cycle 1
    chk("r_d_gnt_c1", 32'(a_d_gnt), 32'd1);
    a_d_req = 1'b0;
    step();  // cycle 2 (WAIT)
    #2 reset = 1'b1;
    #1;  // still before the next clock edge
    chk("r_busy_async", 32'(a_busy), 32'd0);
    chk("r_mem_rd_wr_async", 32'(a_mem_rd_wr), 32'd1);
    chk("r_mem_addr_async", a_mem_addr, 32'd0);
    chk("r_if_rdata_async", a_if_rdata, 32'd0);
    chk("r_d_rdata_async", a_d_rdata, 32'd0);
    step();
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("r_no_rvalid_c%0d", c), {30'd0, a_if_rvalid, a_d_rvalid}, 32'd0);
    end
    a_if_req = 1'b1; a_if_addr = 32'h8002_0000;
    a_d_req = 1'b1; a_d_addr = 32'h9000_0500;
    step();  // cycle 1
    chk("r_d_first_gnt", 32'(a_d_gnt), 32'd1);
    chk("r_if_not_gnt", 32'(a_if_gnt), 32'd0);
    a_if_req = 1'b0; a_d_req = 1'b0;
    step(); step(); step(); step();  // cycle 5
    chk("r_busy_c5", 32'(a_busy), 32'd0);

    // ---------------- MEM_LATENCY = 1 ----------------
    b_if_req = 1'b1; b_if_addr = 32'h8002_0000;
    for (int c = 1; c <= 10; c++) begin
      step();
      chk($sformatf("b_if_gnt_c%0d", c), 32'(b_if_gnt), 32'(c == 1 || c == 4 || c == 7));
      chk($sformatf("b_mem_en_c%0d", c), 32'(b_mem_en), 32'(c == 1 || c == 4 || c == 7));
      chk($sformatf("b_if_rvalid_c%0d", c), 32'(b_if_rvalid), 32'(c == 3 || c == 6 || c == 9));
      if (c == 3 || c == 6 || c == 9) chk($sformatf("b_if_rdata_c%0d", c), b_if_rdata, 32'h2402_0005);
      if (c == 7) b_if_req = 1'b0;
    end
    chk("b_busy_c10", 32'(b_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
